vector_seq: RTL and testbench

Controller that sequences the vector extension datapath: pointer register R2, 8-bit data memory, X1/X2 vector latches, T0..T3 element registers and VRF write port. The main FSM decodes VLOAD/VSTORE/VADD, pulses start with an op code and stalls on busy until done. While busy, the top level routes this block's memory and datapath controls in place of the main FSM's.

---
 rtl/vector_seq_pkg.sv | 54 +++++
 rtl/vector_seq_decode.sv | 79 +++++++
 rtl/vector_seq.sv | 87 ++++++++
 tb/tb_vector_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_seq_pkg.sv
// Shared definitions for the vector-extension sequencer: op codes, FSM states,
// memory write-data mux codes and the decoded control vector.
package vector_seq_pkg;

    typedef enum logic [1:0] {
        VOP_VLOAD  = 2'b00,
        VOP_VSTORE = 2'b01,
        VOP_VADD   = 2'b10,
        VOP_NOP    = 2'b11
    } vop_e;

    typedef enum logic [4:0] {
        S_IDLE,
        S_LDPTR_L, S_RD0, S_RD1, S_RD2, S_RD3, S_RDL, S_WB_L,
        S_LDPTR_S, S_WR0, S_WR1, S_WR2, S_WR3,
        S_VRD, S_ADD, S_WB_A,
        S_NOPD
    } state_e;

    localparam logic [2:0] MI_X1B0 = 3'b000;
    localparam logic [2:0] MI_X1B1 = 3'b001;
    localparam logic [2:0] MI_X1B2 = 3'b010;
    localparam logic [2:0] MI_X1B3 = 3'b011;
    localparam logic [2:0] MI_R1   = 3'b100;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       r2_sel;
        logic       r2_ld;
        logic       addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_in;
        logic       x1_load;
        logic       x2_load;
        logic       vout_sel;
        logic       t0_ld;
        logic       t1_ld;
        logic       t2_ld;
        logic       t3_ld;
        logic       vrf_write;
    } ctrl_t;

    function automatic state_e entry_state(input vop_e op);
        case (op)
            VOP_VLOAD:  entry_state = S_LDPTR_L;
            VOP_VSTORE: entry_state = S_LDPTR_S;
            VOP_VADD:   entry_state = S_VRD;
            default:    entry_state = S_NOPD;
        endcase
    endfunction

endpackage

// File: rtl/vector_seq_decode.sv
// Pure state -> control-vector decode for the vector sequencer (Moore outputs).
module vector_seq_decode
    import vector_seq_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.mem_in = MI_R1;
        ctrl.busy   = (state != S_IDLE);
        case (state)
            S_LDPTR_L: ctrl.r2_ld = 1'b1;
            S_RD0: begin
                ctrl.mem_read = 1'b1;
                ctrl.r2_ld    = 1'b1;
                ctrl.r2_sel   = 1'b1;
            end
            // q of the previous read lands here; element 0 goes to T3
            S_RD1: begin
                ctrl.mem_read = 1'b1;
                ctrl.r2_ld    = 1'b1;
                ctrl.r2_sel   = 1'b1;
                ctrl.vout_sel = 1'b1;
                ctrl.t3_ld    = 1'b1;
            end
            S_RD2: begin
                ctrl.mem_read = 1'b1;
                ctrl.r2_ld    = 1'b1;
                ctrl.r2_sel   = 1'b1;
                ctrl.vout_sel = 1'b1;
                ctrl.t2_ld    = 1'b1;
            end
            S_RD3: begin
                ctrl.mem_read = 1'b1;
                ctrl.vout_sel = 1'b1;
                ctrl.t1_ld    = 1'b1;
            end
            S_RDL: begin
                ctrl.vout_sel = 1'b1;
                ctrl.t0_ld    = 1'b1;
            end
            S_WB_L, S_WB_A: begin
                ctrl.vrf_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_LDPTR_S: begin
                ctrl.r2_ld   = 1'b1;
                ctrl.x1_load = 1'b1;
            end
            S_WR0, S_WR1, S_WR2: begin
                ctrl.mem_write = 1'b1;
                ctrl.r2_ld     = 1'b1;
                ctrl.r2_sel    = 1'b1;
                ctrl.mem_in    = (state == S_WR0) ? MI_X1B0 :
                                 (state == S_WR1) ? MI_X1B1 : MI_X1B2;
            end
            S_WR3: begin
                ctrl.mem_write = 1'b1;
                ctrl.mem_in    = MI_X1B3;
                ctrl.done      = 1'b1;
            end
            S_VRD: begin
                ctrl.x1_load = 1'b1;
                ctrl.x2_load = 1'b1;
            end
            S_ADD: begin
                ctrl.t0_ld = 1'b1;
                ctrl.t1_ld = 1'b1;
                ctrl.t2_ld = 1'b1;
                ctrl.t3_ld = 1'b1;
            end
            S_NOPD: ctrl.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/vector_seq.sv
// Vector-extension sequencer: state register and next-state logic; all
// datapath/memory controls are decoded from the registered state.
module vector_seq
    import vector_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_ELEM = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic       R2Sel,
    output logic       R2Ld,
    output logic       AddrSel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [2:0] MemIn,
    output logic       X1Load,
    output logic       X2Load,
    output logic       VoutSel,
    output logic       T0Ld,
    output logic       T1Ld,
    output logic       T2Ld,
    output logic       T3Ld,
    output logic       VRFWrite
);

    // The element sequence is hard-wired for four bytes into a 32-bit VRF word.
    if (N_ELEM != 4 || DATA_W * N_ELEM != 32) begin : g_bad_cfg
        $error("vector_seq supports only DATA_W=8, N_ELEM=4");
    end

    state_e state;
    state_e next_state;
    ctrl_t  ctrl;

    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = entry_state(vop_e'(op));
            S_LDPTR_L: next_state = S_RD0;
            S_RD0:     next_state = S_RD1;
            S_RD1:     next_state = S_RD2;
            S_RD2:     next_state = S_RD3;
            S_RD3:     next_state = S_RDL;
            S_RDL:     next_state = S_WB_L;
            S_LDPTR_S: next_state = S_WR0;
            S_WR0:     next_state = S_WR1;
            S_WR1:     next_state = S_WR2;
            S_WR2:     next_state = S_WR3;
            S_VRD:     next_state = S_ADD;
            S_ADD:     next_state = S_WB_A;
            default:   next_state = S_IDLE;
        endcase
    end

    vector_seq_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign busy     = ctrl.busy;
    assign done     = ctrl.done;
    assign R2Sel    = ctrl.r2_sel;
    assign R2Ld     = ctrl.r2_ld;
    assign AddrSel  = ctrl.addr_sel;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign MemIn    = ctrl.mem_in;
    assign X1Load   = ctrl.x1_load;
    assign X2Load   = ctrl.x2_load;
    assign VoutSel  = ctrl.vout_sel;
    assign T0Ld     = ctrl.t0_ld;
    assign T1Ld     = ctrl.t1_ld;
    assign T2Ld     = ctrl.t2_ld;
    assign T3Ld     = ctrl.t3_ld;
    assign VRFWrite = ctrl.vrf_write;

endmodule

// File: tb/tb_vector_seq.sv
// Bench for vector_seq: a small behavioural datapath (R2, memory, X1/X2, T regs,
// VRF write capture) driven by the DUT controls, with directed vectors.
module tb_vector_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic       busy, done, R2Sel, R2Ld, AddrSel, MemRead, MemWrite;
    logic [2:0] MemIn;
    logic       X1Load, X2Load, VoutSel, T0Ld, T1Ld, T2Ld, T3Ld, VRFWrite;

    int n_checks = 0;
    int n_fail   = 0;

    vector_seq #(.DATA_W(8), .N_ELEM(4)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .busy(busy), .done(done), .R2Sel(R2Sel), .R2Ld(R2Ld), .AddrSel(AddrSel),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemIn(MemIn),
        .X1Load(X1Load), .X2Load(X2Load), .VoutSel(VoutSel),
        .T0Ld(T0Ld), .T1Ld(T1Ld), .T2Ld(T2Ld), .T3Ld(T3Ld), .VRFWrite(VRFWrite)
    );

    always #5 clock = ~clock;

    // datapath model
    logic [7:0]  rf2, r1, r2, q, t0, t1, t2, t3, addr, wdata;
    logic [31:0] vrf1, vrf2, x1, x2, vdataw;
    logic [7:0]  mem [256];
    int          vrf_wr_total = 0;

    assign addr  = AddrSel ? 8'h00 : r2;
    assign wdata = (MemIn == 3'b000) ? x1[31:24] : (MemIn == 3'b001) ? x1[23:16] :
                   (MemIn == 3'b010) ? x1[15:8]  : (MemIn == 3'b011) ? x1[7:0] : r1;

    always @(posedge clock) begin
        if (!reset) begin
            mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22; mem[8'h12] <= 8'h33; mem[8'h13] <= 8'h44;
            mem[8'hFE] <= 8'h5A; mem[8'hFF] <= 8'h6B; mem[8'h00] <= 8'h7C; mem[8'h01] <= 8'h8D;
        end
        if (MemWrite) mem[addr] <= wdata;
        if (MemRead)  q <= mem[addr];
        if (R2Ld)     r2 <= R2Sel ? r2 + 8'd1 : rf2;
        if (X1Load)   x1 <= vrf1;
        if (X2Load)   x2 <= vrf2;
        if (T3Ld)     t3 <= VoutSel ? q : 8'(x1[31:24] + x2[31:24]);
        if (T2Ld)     t2 <= VoutSel ? q : 8'(x1[23:16] + x2[23:16]);
        if (T1Ld)     t1 <= VoutSel ? q : 8'(x1[15:8]  + x2[15:8]);
        if (T0Ld)     t0 <= VoutSel ? q : 8'(x1[7:0]   + x2[7:0]);
        if (VRFWrite) begin
            vdataw <= {t3, t2, t1, t0};
            vrf_wr_total <= vrf_wr_total + 1;
        end
    end

    logic [17:0] all_out;
    assign all_out = {busy, done, R2Sel, R2Ld, AddrSel, MemRead, MemWrite, MemIn,
                      X1Load, X2Load, VoutSel, T0Ld, T1Ld, T2Ld, T3Ld, VRFWrite};
    localparam logic [17:0] IDLE_OUT = {7'b0, 3'b100, 8'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle invariants
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
            check("vrfw_x1load_exclusive", {31'b0, VRFWrite & X1Load}, 32'd0);
            if (busy === 1'b0) check("idle_outputs", {14'b0, all_out}, {14'b0, IDLE_OUT});
        end
    end

    task automatic run_op(input logic [1:0] o, output int nbusy, output int done_at,
                          output int ndone, output int vrfw_at, output int nvrfw,
                          output int nmemw, output int nen);
        nbusy = 0; done_at = 0; ndone = 0; vrfw_at = 0; nvrfw = 0; nmemw = 0; nen = 0;
        @(negedge clock);
        start = 1'b1; op = o;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            nbusy++;
            if (done) begin ndone++; done_at = nbusy; end
            if (VRFWrite) begin nvrfw++; vrfw_at = nbusy; end
            if (MemWrite) nmemw++;
            if (R2Sel | R2Ld | MemRead | MemWrite | X1Load | X2Load | VoutSel |
                T0Ld | T1Ld | T2Ld | T3Ld | VRFWrite) nen++;
            @(negedge clock);
        end
        check("op_timeout", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  rf2;
        logic [31:0] vrf1;
        logic [31:0] vrf2;
        int          exp_busy;
        int          exp_vrfw;
        logic [31:0] exp_vdata;
        logic [7:0]  exp_r2;
        int          exp_memw;
        bit          exp_quiet;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nbusy, done_at, ndone, vrfw_at, nvrfw, nmemw, nen, wr_before;

        vecs[0] = '{2'b00, 8'h10, 32'h0,        32'h0,        7, 1, 32'h11223344, 8'h13, 0, 1'b0};
        vecs[1] = '{2'b01, 8'h20, 32'hA1B2C3D4, 32'h0,        5, 0, 32'h0,        8'h23, 4, 1'b0};
        vecs[2] = '{2'b10, 8'h00, 32'hFF017F80, 32'h01017F80, 3, 1, 32'h0002FE00, 8'h23, 0, 1'b0};
        vecs[3] = '{2'b11, 8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        8'h23, 0, 1'b1};
        vecs[4] = '{2'b00, 8'hFE, 32'h0,        32'h0,        7, 1, 32'h5A6B7C8D, 8'h01, 0, 1'b0};

        reset = 1'b0; start = 1'b0; op = 2'b00;
        rf2 = 8'h00; r1 = 8'hEE; vrf1 = '0; vrf2 = '0;
        repeat (3) @(negedge clock);
        check("reset_state", {14'b0, all_out}, {14'b0, IDLE_OUT});
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            rf2 = vecs[i].rf2; vrf1 = vecs[i].vrf1; vrf2 = vecs[i].vrf2;
            run_op(vecs[i].op, nbusy, done_at, ndone, vrfw_at, nvrfw, nmemw, nen);
            check($sformatf("v%0d_busy_cycles", i), nbusy, vecs[i].exp_busy);
            check($sformatf("v%0d_done_count", i), ndone, 1);
            check($sformatf("v%0d_done_cycle", i), done_at, vecs[i].exp_busy);
            check($sformatf("v%0d_vrf_writes", i), nvrfw, vecs[i].exp_vrfw);
            if (vecs[i].exp_vrfw > 0) begin
                check($sformatf("v%0d_vrfw_cycle", i), vrfw_at, vecs[i].exp_busy);
                check($sformatf("v%0d_vdata", i), vdataw, vecs[i].exp_vdata);
            end
            check($sformatf("v%0d_r2", i), {24'b0, r2}, {24'b0, vecs[i].exp_r2});
            check($sformatf("v%0d_mem_writes", i), nmemw, vecs[i].exp_memw);
            if (vecs[i].exp_quiet) check($sformatf("v%0d_no_enables", i), nen, 0);
        end

        check("store_mem20", {24'b0, mem[8'h20]}, 32'hA1);
        check("store_mem21", {24'b0, mem[8'h21]}, 32'hB2);
        check("store_mem22", {24'b0, mem[8'h22]}, 32'hC3);
        check("store_mem23", {24'b0, mem[8'h23]}, 32'hD4);

        // start held high through a VLOAD, with op switched to VSTORE while busy
        rf2 = 8'h10; vrf1 = 32'h55667788;
        @(negedge clock);
        start = 1'b1; op = 2'b00;
        @(negedge clock);
        op = 2'b01;
        nbusy = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            nbusy++;
            if (done) ndone++;
            if (nbusy == 2) rf2 = 8'h40;
            @(negedge clock);
        end
        check("hold_start_busy_cycles", nbusy, 7);
        check("hold_start_done_count", ndone, 1);
        check("hold_start_vdata", vdataw, 32'h11223344);
        @(negedge clock);
        start = 1'b0;
        check("backtoback_busy", {31'b0, busy}, 32'd1);
        check("backtoback_vstore_x1load", {31'b0, X1Load}, 32'd1);
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            @(negedge clock);
        end
        check("backtoback_finish", {31'b0, busy}, 32'd0);
        check("backtoback_mem43", {24'b0, mem[8'h43]}, 32'h88);

        // reset asserted while in RD2 of a VLOAD
        rf2 = 8'h10;
        @(negedge clock);
        start = 1'b1; op = 2'b00;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_in_rd2", {31'b0, T2Ld}, 32'd1);
        wr_before = vrf_wr_total;
        reset = 1'b0;
        @(negedge clock);
        check("abort_outputs", {14'b0, all_out}, {14'b0, IDLE_OUT});
        reset = 1'b1;
        repeat (8) @(negedge clock);
        check("abort_stays_idle", {31'b0, busy}, 32'd0);
        check("abort_no_vrfwrite", vrf_wr_total, wr_before);

        vrf1 = 32'h12345678; vrf2 = 32'h11111111;
        run_op(2'b10, nbusy, done_at, ndone, vrfw_at, nvrfw, nmemw, nen);
        check("post_abort_vadd_busy", nbusy, 3);
        check("post_abort_vadd_vdata", vdataw, 32'h23456789);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
